// File: rtl/ui_mem_pkg.sv
// ui_mem_pkg: command codes, FSM states and sizing constants shared by the UI memory responder.
package ui_mem_pkg;
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam int WDF_DEPTH = 4;
  localparam int ERR_CMD = 0;
  localparam int ERR_OVF = 1;
  typedef enum logic [1:0] {S_CALIB, S_IDLE, S_WR_WAIT} state_t;
endpackage

// File: rtl/ui_mem_responder_if.sv
// ui_mem_responder_if: MIG-style UI command, write-data and read-data channels.
interface ui_mem_responder_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 256,
  parameter int MASK_W = 32
);
  logic              app_en;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic              app_rdy;
  logic              app_wdf_wren;
  logic [DATA_W-1:0] app_wdf_data;
  logic              app_wdf_end;
  logic [MASK_W-1:0] app_wdf_mask;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;
  logic              app_rd_data_end;
  modport master (
    output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_data, app_wdf_end, app_wdf_mask,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );
  modport slave (
    input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_data, app_wdf_end, app_wdf_mask,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );
endinterface

// File: rtl/ui_wdf_fifo.sv
// ui_wdf_fifo: 4-deep show-ahead FIFO holding {data, mask} words until a write command claims them.
module ui_wdf_fifo
  import ui_mem_pkg::*;
#(
  parameter int W = 288
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push_i,
  input  logic [W-1:0]                 data_i,
  input  logic                         pop_i,
  output logic [W-1:0]                 head_o,
  output logic [$clog2(WDF_DEPTH):0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);
  localparam int PW = $clog2(WDF_DEPTH);
  logic [W-1:0]  mem_q [WDF_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0]   count_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + 1'b1;
      if (pop_i) rp_q <= rp_q + 1'b1;
      count_q <= count_q + {{PW{1'b0}}, push_i} - {{PW{1'b0}}, pop_i};
    end
  always_ff @(posedge clk)
    if (push_i) mem_q[wp_q] <= data_i;
  assign head_o  = mem_q[rp_q];
  assign count_o = count_q;
  assign full_o  = count_q[PW];
  assign empty_o = count_q == '0;
endmodule

// File: rtl/ui_mem_responder.sv
// ui_mem_responder: BRAM-backed stand-in for the DDR3 UI port with calibration delay and fixed read latency.
// Define UI_RESP_BACKPRESSURE_EN to throttle app_rdy/app_wdf_rdy from a free-running LFSR.
module ui_mem_responder
  import ui_mem_pkg::*;
#(
  parameter int ADDR_W         = 30,
  parameter int DATA_W         = 256,
  parameter int MASK_W         = 32,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int RD_LATENCY     = 4,
  parameter int CALIB_CYCLES   = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               calib_done,
  output logic [1:0]         err_flags,
  ui_mem_responder_if.slave  bus
);
  localparam int CW = $clog2(CALIB_CYCLES + 1);
  localparam int IW = MEM_DEPTH_LOG2;
  state_t                     state_q, state_d;
  logic [CW-1:0]              cnt_q;
  logic                       rdy_q, app_rdy, wdf_rdy;
  logic                       acc, is_wr, is_rd, is_bad, commit, push, ovf;
  logic [IW-1:0]              cmd_idx, wr_idx_q, w_idx;
  logic [1:0]                 err_q;
  logic                       fifo_full, fifo_empty;
  logic [$clog2(WDF_DEPTH):0] fifo_count;
  logic [DATA_W+MASK_W-1:0]   head;
  logic [DATA_W-1:0]          mem [2**IW];
  logic [DATA_W-1:0]          rd_pipe_q [RD_LATENCY-1];
  logic [RD_LATENCY-1:0]      v_q;
  logic [DATA_W-1:0]          rd_data_q;
  logic                       unused_ok;
`ifdef UI_RESP_BACKPRESSURE_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) lfsr_q <= 16'hACE1;
    else lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign app_rdy = rdy_q && (lfsr_q[1:0] != 2'b00);
  assign wdf_rdy = (state_q != S_CALIB) && !fifo_full && (lfsr_q[9:8] != 2'b00);
`else
  assign app_rdy = rdy_q;
  assign wdf_rdy = (state_q != S_CALIB) && !fifo_full;
`endif
  assign cmd_idx = bus.app_addr[IW+2:3];
  assign w_idx   = (state_q == S_WR_WAIT) ? wr_idx_q : cmd_idx;
  always_comb begin
    acc     = bus.app_en && app_rdy;
    is_wr   = acc && (bus.app_cmd == CMD_WRITE);
    is_rd   = acc && (bus.app_cmd == CMD_READ);
    is_bad  = acc && !is_wr && !is_rd;
    commit  = !fifo_empty && (is_wr || state_q == S_WR_WAIT);
    push    = bus.app_wdf_wren && wdf_rdy;
    ovf     = bus.app_wdf_wren && fifo_full;
    state_d = (state_q == S_CALIB) ? ((cnt_q == CW'(CALIB_CYCLES - 1)) ? S_IDLE : S_CALIB) :
              (state_q == S_IDLE)  ? ((is_wr && fifo_empty) ? S_WR_WAIT : S_IDLE) :
              (fifo_empty ? S_WR_WAIT : S_IDLE);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= S_CALIB;
      cnt_q     <= '0;
      rdy_q     <= 1'b0;
      wr_idx_q  <= '0;
      err_q     <= '0;
      v_q       <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_CALIB) cnt_q <= cnt_q + 1'b1;
      rdy_q <= state_d == S_IDLE;
      if (is_wr) wr_idx_q <= cmd_idx;
      err_q[ERR_CMD] <= err_q[ERR_CMD] | is_bad;
      err_q[ERR_OVF] <= err_q[ERR_OVF] | ovf;
      v_q <= {v_q[RD_LATENCY-2:0], is_rd};
      if (v_q[RD_LATENCY-2]) rd_data_q <= rd_pipe_q[RD_LATENCY-2];
    end
  // Array and read-data pipeline carry no reset so the array maps onto byte-enabled block RAM.
  always_ff @(posedge clk) begin
    if (is_rd) rd_pipe_q[0] <= mem[cmd_idx];
    for (int j = 1; j < RD_LATENCY - 1; j++) rd_pipe_q[j] <= rd_pipe_q[j-1];
    if (commit)
      for (int b = 0; b < MASK_W; b++)
        if (!head[b]) mem[w_idx][8*b +: 8] <= head[MASK_W + 8*b +: 8];
  end
  ui_wdf_fifo #(.W(DATA_W + MASK_W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .data_i  ({bus.app_wdf_data, bus.app_wdf_mask}),
    .pop_i   (commit),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
  assign calib_done            = state_q != S_CALIB;
  assign err_flags             = err_q;
  assign bus.app_rdy           = app_rdy;
  assign bus.app_wdf_rdy       = wdf_rdy;
  assign bus.app_rd_data       = rd_data_q;
  assign bus.app_rd_data_valid = v_q[RD_LATENCY-1];
  assign bus.app_rd_data_end   = v_q[RD_LATENCY-1];
  assign unused_ok = ^{bus.app_wdf_end, bus.app_addr, fifo_count};
endmodule

// File: tb/tb_ui_mem_responder.sv
// tb_ui_mem_responder: directed and randomized UI traffic checked by a queue scoreboard
// against a behavioural memory model (in-order command/word pairing, byte masks, fixed latency).
module tb_ui_mem_responder;
  import ui_mem_pkg::*;
  localparam int L = 4;
  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       calib_done;
  logic [1:0] err_flags;
  int checks = 0, failures = 0, cyc = 0;
  logic [255:0] pat, pat2;
  logic [255:0] mdl [1024];
  int           cq[$];
  logic [287:0] wq[$];
  logic [255:0] exp_q[$];
  int           due_q[$];
  logic [287:0] mw;
  int           mi;

  ui_mem_responder_if u_if ();
  ui_mem_responder dut (.clk(clk), .reset_n(reset_n), .calib_done(calib_done), .err_flags(err_flags), .bus(u_if));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string n, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Monitor + reference model: words and write commands pair in arrival order.
  always @(negedge clk) begin
    if (!reset_n) begin
      check("rd_valid_in_reset", u_if.app_rd_data_valid, 0);
      cq.delete(); wq.delete(); exp_q.delete(); due_q.delete();
    end else begin
      if (u_if.app_rd_data_valid) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_unexpected actual=valid required=no pending read");
        end else begin
          check("rd_data", u_if.app_rd_data, exp_q.pop_front());
          check("rd_latency", cyc, due_q.pop_front());
          check("rd_end", u_if.app_rd_data_end, 1);
        end
      end else if (due_q.size() > 0 && due_q[0] < cyc) begin
        checks++; failures++;
        $display("FAIL rd_missing actual=no valid required=valid at cycle %0d", due_q[0]);
        void'(exp_q.pop_front()); void'(due_q.pop_front());
      end
      if (u_if.app_wdf_wren && u_if.app_wdf_rdy) wq.push_back({u_if.app_wdf_data, u_if.app_wdf_mask});
      if (u_if.app_en && u_if.app_rdy && u_if.app_cmd == CMD_WRITE) cq.push_back(int'(u_if.app_addr[12:3]));
      while (cq.size() > 0 && wq.size() > 0) begin
        mw = wq.pop_front(); mi = cq.pop_front();
        for (int b = 0; b < 32; b++) if (!mw[b]) mdl[mi][8*b +: 8] = mw[32 + 8*b +: 8];
      end
      if (u_if.app_en && u_if.app_rdy && u_if.app_cmd == CMD_READ) begin
        exp_q.push_back(mdl[u_if.app_addr[12:3]]);
        due_q.push_back(cyc + L);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cmd(input logic [2:0] c, input logic [29:0] a);
    bit ok = 0;
    u_if.app_en = 1; u_if.app_cmd = c; u_if.app_addr = a;
    for (int t = 0; t < 100 && !ok; t++) begin ok = u_if.app_rdy; @(posedge clk); #1; end
    if (!ok) begin checks++; failures++; $display("FAIL cmd_timeout actual=app_rdy low required=accept within 100 cycles"); end
    u_if.app_en = 0;
  endtask

  task automatic wdata(input logic [255:0] d, input logic [31:0] m);
    bit ok = 0;
    u_if.app_wdf_wren = 1; u_if.app_wdf_end = 1; u_if.app_wdf_data = d; u_if.app_wdf_mask = m;
    for (int t = 0; t < 100 && !ok; t++) begin ok = u_if.app_wdf_rdy; @(posedge clk); #1; end
    if (!ok) begin checks++; failures++; $display("FAIL wdf_timeout actual=app_wdf_rdy low required=accept within 100 cycles"); end
    u_if.app_wdf_wren = 0; u_if.app_wdf_end = 0;
  endtask

  task automatic read_expect(input string n, input logic [29:0] a, input logic [255:0] e);
    bit seen = 0;
    cmd(CMD_READ, a);
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (u_if.app_rd_data_valid) begin seen = 1; check(n, u_if.app_rd_data, e); end
    end
    if (!seen) begin checks++; failures++; $display("FAIL %s actual=no read data required=read data within 20 cycles", n); end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && exp_q.size() > 0; t++) begin @(posedge clk); #1; end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic check_zero_outputs(input string n);
    check({n, "_calib"}, calib_done, 0);
    check({n, "_rdy"}, u_if.app_rdy, 0);
    check({n, "_wdf_rdy"}, u_if.app_wdf_rdy, 0);
    check({n, "_valid"}, {u_if.app_rd_data_valid, u_if.app_rd_data_end}, 0);
    check({n, "_rd_data"}, u_if.app_rd_data, 0);
    check({n, "_err"}, err_flags, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0]  a;
    logic [255:0] d;
    pat  = {4{64'h0123_4567_89AB_CDEF}};
    pat2 = {8{32'hDEAD_BEEF}};
    u_if.app_en = 0; u_if.app_cmd = 0; u_if.app_addr = 0;
    u_if.app_wdf_wren = 0; u_if.app_wdf_data = 0; u_if.app_wdf_mask = 0; u_if.app_wdf_end = 0;
    #2 reset_n = 0;
    repeat (3) @(posedge clk);
    #1 check_zero_outputs("reset");
    // Calibration: command held pending; nothing may be accepted before calib_done.
    u_if.app_en = 1; u_if.app_cmd = CMD_READ; u_if.app_addr = 30'h8;
    reset_n = 1;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk); #1;
      check("calib_done", calib_done, k == 64);
      check("calib_rdy", u_if.app_rdy, k == 64);
      check("calib_wdf_rdy", u_if.app_wdf_rdy, k == 64);
    end
    u_if.app_en = 0;
    check("calib_err", err_flags, 0);
    // Write then read.
    wdata(pat, 32'h0);
    cmd(CMD_WRITE, 30'h8);
    read_expect("wr_rd", 30'h8, pat);
    // Late write data.
    cmd(CMD_WRITE, 30'h10);
    check("late_rdy_drop", u_if.app_rdy, 0);
    wait_cycles(2);
    wdata(pat2, 32'h0);
    check("late_rdy_wait", u_if.app_rdy, 0);
    wait_cycles(1);
    check("late_rdy_back", u_if.app_rdy, 1);
    read_expect("late_rd", 30'h10, pat2);
    // Mask and address wrap.
    wdata('0, 32'h0);
    cmd(CMD_WRITE, 30'h0);
    wdata('1, 32'h1);
    cmd(CMD_WRITE, 30'h2000);
    read_expect("mask_wrap", 30'h0, {{31{8'hFF}}, 8'h00});
    // Errors: invalid command then FIFO overflow.
    cmd(3'b010, 30'h0);
    check("err_cmd", err_flags, 2'b01);
    u_if.app_wdf_end = 1;
    for (int k = 0; k < 5; k++) begin
      u_if.app_wdf_wren = 1; u_if.app_wdf_data = {8{32'(k + 1)}}; u_if.app_wdf_mask = 0;
      @(posedge clk); #1;
    end
    u_if.app_wdf_wren = 0; u_if.app_wdf_end = 0;
    check("err_ovf", err_flags, 2'b11);
    check("fifo_full_rdy", u_if.app_wdf_rdy, 0);
    for (int k = 0; k < 4; k++) cmd(CMD_WRITE, 30'((k + 4) << 3));
    fork
      cmd(CMD_WRITE, 30'h40);
      wdata({8{32'h55AA_33CC}}, 32'h0);
    join
    for (int k = 0; k < 4; k++) read_expect("ovf_kept", 30'((k + 4) << 3), {8{32'(k + 1)}});
    read_expect("ovf_dropped", 30'h40, {8{32'h55AA_33CC}});
    // Reset with three reads in flight.
    u_if.app_en = 1; u_if.app_cmd = CMD_READ;
    for (int k = 0; k < 3; k++) begin u_if.app_addr = 30'((k + 1) << 3); @(posedge clk); #1; end
    u_if.app_en = 0;
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1 check_zero_outputs("mid_reset");
    reset_n = 1;
    for (int t = 0; t < 100 && !calib_done; t++) begin @(posedge clk); #1; end
    check("recal_done", calib_done, 1);
    read_expect("post_reset_kept", 30'h8, pat);
    read_expect("post_reset_kept2", 30'h10, pat2);
    // Randomized traffic over 16 slots reached through random upper address bits.
    for (int k = 0; k < 16; k++) begin
      wdata(rnd256(), 32'h0);
      cmd(CMD_WRITE, 30'(k << 3));
    end
    for (int n = 0; n < 300; n++) begin
      a = (30'($urandom) & 30'h3FFF_E007) | (30'($urandom_range(0, 15)) << 3);
      d = rnd256();
      case ($urandom_range(0, 3))
        0: cmd(CMD_READ, a);
        1: begin wdata(d, $urandom_range(0, 1) ? $urandom : 32'h0); cmd(CMD_WRITE, a); end
        2: fork
             cmd(CMD_WRITE, a);
             begin wait_cycles($urandom_range(0, 3)); wdata(d, $urandom_range(0, 1) ? $urandom : 32'h0); end
           join
        default: wait_cycles($urandom_range(0, 2));
      endcase
    end
    drain();
    check("pairs_left", cq.size() + wq.size(), 0);
    check("final_err", err_flags, 2'b00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
